// File: rtl/cavlc_bit_packer.sv
// Serial-to-word packer for the CAVLC bitstream: MSB-first packing, zero-pad on flush,
// and a small first-word-fall-through output FIFO drained with valid/ready.
module cavlc_bit_packer #(
    parameter int WORD_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_bit_data,
    input  logic                  i_bit_push,
    input  logic                  i_flush,
    output logic                  o_flush_done,
    output logic [WORD_WIDTH-1:0] o_word_data,
    output logic                  o_word_valid,
    input  logic                  i_word_ready,
    output logic                  o_overflow,
    output logic [CNT_WIDTH-1:0]  o_bit_count
);
    localparam int FW = $clog2(WORD_WIDTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [FW-1:0] WORD_C  = FW'(WORD_WIDTH);

    typedef enum logic {PACK, FLUSH_WAIT} state_t;

    state_t                r_state, w_state_n;
    logic [WORD_WIDTH-1:0] r_shift, w_shift_n, w_shift_p, w_enq_word;
    logic [FW-1:0]         r_fill, w_fill_n, w_fill_p;
    logic [WORD_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_done, r_ovf;
    logic [CNT_WIDTH-1:0]  r_bit_count;

    logic w_deq, w_can_enq, w_enq, w_done_n, w_ovf_set, w_bit_acc;

    assign w_deq     = (r_count != '0) && i_word_ready;
    // A full FIFO still takes a word when the head leaves on the same edge.
    assign w_can_enq = (r_count != DEPTH_C) || w_deq;

    always_comb begin
        w_shift_p = r_shift;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (i_bit_push && ((WORD_WIDTH - 1 - i) == int'(r_fill)))
                w_shift_p[i] = i_bit_data;
        end
        w_fill_p = r_fill + FW'(i_bit_push);
    end

    always_comb begin
        w_state_n  = r_state;
        w_shift_n  = r_shift;
        w_fill_n   = r_fill;
        w_enq      = 1'b0;
        w_enq_word = r_shift;
        w_done_n   = 1'b0;
        w_ovf_set  = 1'b0;
        w_bit_acc  = 1'b0;
        case (r_state)
            PACK: begin
                w_bit_acc = i_bit_push;
                if (w_fill_p == WORD_C) begin
                    w_enq_word = w_shift_p;
                    w_shift_n  = '0;
                    w_fill_n   = '0;
                    w_enq      = w_can_enq;
                    w_ovf_set  = !w_can_enq;
                    w_done_n   = i_flush;
                end else if (i_flush) begin
                    if (w_fill_p == '0) begin
                        w_done_n = 1'b1;
                    end else begin
                        w_enq_word = w_shift_p;
                        if (w_can_enq) begin
                            w_enq     = 1'b1;
                            w_shift_n = '0;
                            w_fill_n  = '0;
                            w_done_n  = 1'b1;
                        end else begin
                            // Padded word is never dropped; hold it until space frees up.
                            w_state_n = FLUSH_WAIT;
                            w_shift_n = w_shift_p;
                            w_fill_n  = w_fill_p;
                        end
                    end
                end else begin
                    w_shift_n = w_shift_p;
                    w_fill_n  = w_fill_p;
                end
            end
            FLUSH_WAIT: begin
                w_ovf_set = i_bit_push;
                if (w_can_enq) begin
                    w_enq     = 1'b1;
                    w_shift_n = '0;
                    w_fill_n  = '0;
                    w_done_n  = 1'b1;
                    w_state_n = PACK;
                end
            end
            default: w_state_n = PACK;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= PACK;
            r_shift     <= '0;
            r_fill      <= '0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_bit_count <= '0;
        end else begin
            r_state <= w_state_n;
            r_shift <= w_shift_n;
            r_fill  <= w_fill_n;
            r_done  <= w_done_n;
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_bit_acc && (r_bit_count != '1)) r_bit_count <= r_bit_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_wptr] <= w_enq_word;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_deq) r_rptr <= r_rptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_flush_done = r_done;
    assign o_word_data  = r_mem[r_rptr];
    assign o_word_valid = (r_count != '0);
    assign o_overflow   = r_ovf;
    assign o_bit_count  = r_bit_count;
endmodule

// File: tb/tb_cavlc_bit_packer.sv
// Directed bench for cavlc_bit_packer: per-cycle vector table plus hand-written
// sequences for FIFO-full drops, flush back-pressure and mid-word reset.
module tb_cavlc_bit_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bit_data = 1'b0, bit_push = 1'b0, flush = 1'b0, word_ready = 1'b0;
    logic        flush_done, word_valid, overflow;
    logic [7:0]  word_data;
    logic [15:0] bit_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cavlc_bit_packer #(.WORD_WIDTH(8), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .i_bit_data(bit_data), .i_bit_push(bit_push), .i_flush(flush),
        .o_flush_done(flush_done), .o_word_data(word_data), .o_word_valid(word_valid),
        .i_word_ready(word_ready), .o_overflow(overflow), .o_bit_count(bit_count)
    );

    typedef struct {
        logic        rst_n, d, push, flsh, rdy;
        logic        e_valid;
        logic [7:0]  e_word;
        logic        e_done, e_ovf;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic d, input logic p, input logic f, input logic rd,
                       input logic ev, input logic [7:0] ew, input logic ed, input logic eo,
                       input logic [15:0] ec);
        vec_t v;
        v.rst_n = r; v.d = d; v.push = p; v.flsh = f; v.rdy = rd;
        v.e_valid = ev; v.e_word = ew; v.e_done = ed; v.e_ovf = eo; v.e_cnt = ec;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic d, input logic p, input logic f, input logic rd);
        bit_data = d; bit_push = p; flush = f; word_ready = rd;
        @(posedge clk);
        #1;
        bit_data = 1'b0; bit_push = 1'b0; flush = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic rd);
        for (int i = 7; i >= 0; i--) cyc(b[i], 1'b1, 1'b0, rd);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        // reset state, then test 1: 1,0,1,1,0,0,1,0 -> B2
        add(0,0,0,0,0, 0,8'h00,0,0,16'd0);
        add(1,0,0,0,0, 0,8'h00,0,0,16'd0);
        pat = 8'hB2;
        for (int i = 0; i < 8; i++)
            add(1'b1, pat[7-i], 1'b1, 1'b0, 1'b1, (i == 7), (i == 7) ? 8'hB2 : 8'h00,
                1'b0, 1'b0, 16'(i + 1));
        add(1,0,0,0,1, 0,8'h00,0,0,16'd8);
        // test 2: 1,1,1 + flush -> E0
        add(0,0,0,0,0, 0,8'h00,0,0,16'd0);
        add(1,0,0,0,0, 0,8'h00,0,0,16'd0);
        add(1,1,1,0,0, 0,8'h00,0,0,16'd1);
        add(1,1,1,0,0, 0,8'h00,0,0,16'd2);
        add(1,1,1,0,0, 0,8'h00,0,0,16'd3);
        add(1,0,0,1,0, 1,8'hE0,1,0,16'd3);
        add(1,0,0,0,1, 0,8'h00,0,0,16'd3);
        // test 3: flush with empty fill
        add(1,0,0,1,1, 0,8'h00,1,0,16'd3);
        add(1,0,0,0,1, 0,8'h00,0,0,16'd3);
        // push and flush in the same cycle: push applied first -> 80
        add(1,1,1,1,0, 1,8'h80,1,0,16'd4);
        add(1,0,0,0,1, 0,8'h00,0,0,16'd4);

        rst = 1'b0;
        foreach (tbl[k]) begin
            rst = tbl[k].rst_n;
            cyc(tbl[k].d, tbl[k].push, tbl[k].flsh, tbl[k].rdy);
            chk($sformatf("v%0d_valid", k), 32'(word_valid), 32'(tbl[k].e_valid));
            if (tbl[k].e_valid) chk($sformatf("v%0d_word", k), 32'(word_data), 32'(tbl[k].e_word));
            chk($sformatf("v%0d_done", k), 32'(flush_done), 32'(tbl[k].e_done));
            chk($sformatf("v%0d_ovf", k), 32'(overflow), 32'(tbl[k].e_ovf));
            chk($sformatf("v%0d_cnt", k), 32'(bit_count), 32'(tbl[k].e_cnt));
        end

        // test 4: 5 words of A5 with ready low -> 4 held, 5th dropped
        do_reset();
        for (int k = 0; k < 4; k++) push_byte(8'hA5, 1'b0);
        chk("t4_ovf_before", 32'(overflow), 32'd0);
        push_byte(8'hA5, 1'b0);
        chk("t4_ovf_after", 32'(overflow), 32'd1);
        chk("t4_cnt", 32'(bit_count), 32'd40);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_valid%0d", k), 32'(word_valid), 32'd1);
            chk($sformatf("t4_word%0d", k), 32'(word_data), 32'hA5);
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("t4_empty", 32'(word_valid), 32'd0);
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);

        // test 5: full FIFO, partial 11011 + flush under back-pressure
        do_reset();
        for (int k = 0; k < 4; k++) push_byte(8'hA5, 1'b0);
        pat = 8'hD8;
        for (int i = 7; i >= 3; i--) cyc(pat[i], 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_wait_done0", 32'(flush_done), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_wait_done1", 32'(flush_done), 32'd0);
        chk("t5_ovf_none", 32'(overflow), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_wait_push_ovf", 32'(overflow), 32'd1);
        chk("t5_wait_push_cnt", 32'(bit_count), 32'd37);
        chk("t5_wait_done2", 32'(flush_done), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_done", 32'(flush_done), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_done_once", 32'(flush_done), 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t5_word%0d", k), 32'(word_data), 32'hA5);
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("t5_pad_valid", 32'(word_valid), 32'd1);
        chk("t5_pad_word", 32'(word_data), 32'hD8);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_empty", 32'(word_valid), 32'd0);
        chk("t5_no_redone", 32'(flush_done), 32'd0);

        // test 6: reset mid-word discards the partial bits
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("t6_rst_cnt", 32'(bit_count), 32'd0);
        chk("t6_rst_valid", 32'(word_valid), 32'd0);
        chk("t6_rst_data", 32'(word_data), 32'd0);
        chk("t6_rst_done", 32'(flush_done), 32'd0);
        chk("t6_rst_ovf", 32'(overflow), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        push_byte(8'hFF, 1'b0);
        chk("t6_valid", 32'(word_valid), 32'd1);
        chk("t6_word", 32'(word_data), 32'hFF);
        chk("t6_cnt", 32'(bit_count), 32'd8);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_single", 32'(word_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
